// File: rtl/inst_seq.sv
// Instruction sequencer: captures a program burst into a simple-dual-port RAM, waits a fixed
// start delay, then replays the program loop_cnt times at one instruction per cycle.
module inst_seq #(
  parameter int unsigned INST_WIDTH   = 36,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned START_DELAY  = 18,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_in_v,
  input  logic [INST_WIDTH-1:0] inst_in,
  input  logic [7:0]            loop_cnt,
  output logic                  inst_out_v,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned LenW  = ADDR_WIDTH + 1;
  localparam int unsigned DlyW  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int unsigned Lat   = (READ_LATENCY < 1) ? 1 : READ_LATENCY;

  localparam logic [DlyW-1:0] DlyLast = DlyW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [LenW-1:0] LenFull = LenW'(Depth);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StRun  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            loops_q, loops_d;
  logic [DlyW-1:0]       dly_q, dly_d;
  logic                  ovf_q, ovf_d;
  logic [Lat-1:0]        vld_q, vld_d;
  logic [Lat-1:0]        last_q, last_d;
  logic [INST_WIDTH-1:0] data_q [Lat];
  logic [INST_WIDTH-1:0] data_d [Lat];

  logic [INST_WIDTH-1:0] mem_q [Depth];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic                  rd_last;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    loops_d = loops_q;
    dly_d   = dly_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = len_q[ADDR_WIDTH-1:0];
    rd_en   = 1'b0;
    rd_last = 1'b0;

    case (state_q)
      StIdle: begin
        if (inst_in_v) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          len_d   = LenW'(1);
          pc_d    = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (inst_in_v) begin
          if (len_q == LenFull) begin
            ovf_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            len_d = len_q + LenW'(1);
          end
        end else begin
          loops_d = (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
          dly_d   = '0;
          state_d = (START_DELAY == 0) ? StRun : StWait;
        end
      end
      StWait: begin
        if (dly_q == DlyLast) begin
          state_d = StRun;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end
      StRun: begin
        rd_en = 1'b1;
        // Wrap back to the first instruction with no bubble; the last wrap ends the run.
        if (LenW'(pc_q) == len_q - LenW'(1)) begin
          pc_d    = '0;
          loops_d = loops_q - 8'd1;
          if (loops_q == 8'd1) begin
            rd_last = 1'b1;
            state_d = StIdle;
          end
        end else begin
          pc_d = pc_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Valid, last-read and data travel together; each data stage loads only on a valid beat so
  // inst_out holds its value between runs.
  always_comb begin
    vld_d[0]  = rd_en;
    last_d[0] = rd_last;
    data_d[0] = rd_en ? mem_q[pc_q] : data_q[0];
    for (int k = 1; k < Lat; k++) begin
      vld_d[k]  = vld_q[k-1];
      last_d[k] = last_q[k-1];
      data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      pc_q    <= '0;
      loops_q <= '0;
      dly_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= '0;
      last_q  <= '0;
      for (int k = 0; k < Lat; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      loops_q <= loops_d;
      dly_q   <= dly_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      for (int k = 0; k < Lat; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // RAM array is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= inst_in;
    end
  end

  assign inst_out_v = vld_q[Lat-1];
  assign inst_out   = data_q[Lat-1];
  assign done       = vld_q[Lat-1] & last_q[Lat-1];
  assign busy       = (state_q != StIdle);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_inst_seq.sv
// Scoreboard bench for inst_seq: a default build and a shallow, zero-delay, latency-1 build are
// driven side by side; monitors pop expected words and check data, done, busy and cycle.
module tb_inst_seq;

  typedef struct {
    logic [35:0] d;
    bit          dn;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        v0, v1;
  logic [35:0] din;
  logic [7:0]  lc;
  logic        out_v0, out_v1, busy0, busy1, done0, done1, ovf0, ovf1;
  logic [35:0] out0, out1;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  inst_seq #(
    .INST_WIDTH(36), .ADDR_WIDTH(8), .START_DELAY(18), .READ_LATENCY(2)
  ) u_dut0 (
    .clk(clk), .rst(rst0), .inst_in_v(v0), .inst_in(din), .loop_cnt(lc),
    .inst_out_v(out_v0), .inst_out(out0), .busy(busy0), .done(done0), .overflow(ovf0)
  );

  inst_seq #(
    .INST_WIDTH(36), .ADDR_WIDTH(4), .START_DELAY(0), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .inst_in_v(v1), .inst_in(din), .loop_cnt(lc),
    .inst_out_v(out_v1), .inst_out(out1), .busy(busy1), .done(done1), .overflow(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_out(input int dut, input logic [35:0] d, input logic dn, input logic bz);
    exp_t e;
    vectors++;
    if ((dut == 0 && q0.size() == 0) || (dut == 1 && q1.size() == 0)) begin
      miscompares++;
      $display("FAIL dut%0d unexpected output: got %h done %b at cycle %0d, none required",
               dut, d, dn, cyc);
      return;
    end
    if (dut == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (d !== e.d || dn !== e.dn || cyc != e.cyc || (e.dn && bz !== 1'b0)) begin
      miscompares++;
      $display("FAIL dut%0d output: got data %h done %b cycle %0d busy %b, required data %h done %b cycle %0d busy 0 at done",
               dut, d, dn, cyc, bz, e.d, e.dn, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (out_v0 === 1'b1) check_out(0, out0, done0, busy0);
    else if (done0 === 1'b1) begin
      miscompares++;
      $display("FAIL dut0 done without valid: got 1, required 0 (cycle %0d)", cyc);
    end
  end

  always @(negedge clk) begin
    if (out_v1 === 1'b1) check_out(1, out1, done1, busy1);
    else if (done1 === 1'b1) begin
      miscompares++;
      $display("FAIL dut1 done without valid: got 1, required 0 (cycle %0d)", cyc);
    end
  end

  // Expected stream: first valid at L + 1 + START_DELAY + READ_LATENCY (21 and 2), then gapless.
  task automatic push(input logic [35:0] base, input int n, input logic [7:0] lcv, input int l,
                      input int lim0, input int lim1);
    int loops;
    loops = (lcv == 8'd0) ? 1 : int'(lcv);
    for (int dut = 0; dut < 2; dut++) begin
      int eff, lat, lim, total;
      eff   = (dut == 0) ? ((n > 256) ? 256 : n) : ((n > 16) ? 16 : n);
      lat   = (dut == 0) ? 21 : 2;
      lim   = (dut == 0) ? lim0 : lim1;
      total = eff * loops;
      for (int k = 0; k < total && k < lim; k++) begin
        exp_t e;
        e.d   = base + 36'(k % eff);
        e.dn  = (k == total - 1);
        e.cyc = l + lat + k;
        if (dut == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  task automatic load(input logic [35:0] base, input int n, input logic [7:0] lcv,
                      input int lim0, input int lim1, output int l);
    lc = lcv;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk("busy0 rise", {63'd0, busy0}, 64'd1);
        chk("busy1 rise", {63'd0, busy1}, 64'd1);
      end
      if (i < n) begin
        v0 = 1'b1; v1 = 1'b1; din = base + 36'(i);
      end else begin
        v0 = 1'b0; v1 = 1'b0; din = '0;
      end
    end
    l = cyc;
    push(base, n, lcv, l, lim0, lim1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((busy0 || busy1 || q0.size() != 0 || q1.size() != 0) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    vectors++;
    if (t >= 400) begin
      miscompares++;
      $display("FAIL drain timeout: got %0d/%0d words outstanding, required 0/0",
               q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int l;
    rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0; din = '0; lc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_v0", {63'd0, out_v0}, 64'd0);
    chk("rst out0", {28'd0, out0}, 64'd0);
    chk("rst busy0", {63'd0, busy0}, 64'd0);
    chk("rst done0", {63'd0, done0}, 64'd0);
    chk("rst ovf0", {63'd0, ovf0}, 64'd0);
    chk("rst out_v1", {63'd0, out_v1}, 64'd0);
    chk("rst out1", {28'd0, out1}, 64'd0);
    chk("rst busy1", {63'd0, busy1}, 64'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    load(36'hA00000000, 4, 8'd1, 999, 999, l);
    drain();
    load(36'hB00000000, 3, 8'd3, 999, 999, l);
    drain();
    load(36'hC00000000, 1, 8'd0, 999, 999, l);
    drain();

    load(36'hD00000000, 20, 8'd1, 999, 999, l);
    chk("ovf1 set", {63'd0, ovf1}, 64'd1);
    chk("ovf0 clear", {63'd0, ovf0}, 64'd0);
    drain();
    chk("ovf1 sticky", {63'd0, ovf1}, 64'd1);

    // Junk at L+3..L+4 lands in dut0 WAIT and dut1 RUN; junk at L+22 lands in dut0 RUN only.
    load(36'hE00000000, 5, 8'd2, 999, 999, l);
    repeat (3) @(posedge clk);
    #1; v0 = 1'b1; v1 = 1'b1; din = 36'hFFFFFFFFF;
    @(posedge clk); #1; din = 36'h0DEAD0000;
    @(posedge clk); #1; v0 = 1'b0; v1 = 1'b0; din = '0;
    repeat (17) @(posedge clk);
    #1; v0 = 1'b1; din = 36'h0BAD00BAD;
    @(posedge clk); #1; v0 = 1'b0; din = '0;
    drain();

    // Reset dut1 at L+5 (outputs L+2..L+5 kept) and dut0 at L+23 (outputs L+21..L+23 kept).
    load(36'h123400000, 4, 8'd3, 3, 4, l);
    repeat (5) @(posedge clk);
    #1; rst1 = 1'b1;
    @(posedge clk); #1; rst1 = 1'b0;
    chk("mid-run rst out_v1", {63'd0, out_v1}, 64'd0);
    chk("mid-run rst busy1", {63'd0, busy1}, 64'd0);
    chk("mid-run rst out1", {28'd0, out1}, 64'd0);
    chk("mid-run rst ovf1", {63'd0, ovf1}, 64'd0);
    repeat (17) @(posedge clk);
    #1; rst0 = 1'b1;
    @(posedge clk); #1; rst0 = 1'b0;
    chk("mid-run rst out_v0", {63'd0, out_v0}, 64'd0);
    chk("mid-run rst busy0", {63'd0, busy0}, 64'd0);
    chk("mid-run rst out0", {28'd0, out0}, 64'd0);
    drain();

    load(36'h5A5A00000, 3, 8'd2, 999, 999, l);
    drain();
    chk("final out_v0", {63'd0, out_v0}, 64'd0);
    chk("final out0 hold", {28'd0, out0}, {28'd0, 36'h5A5A00002});
    chk("final out1 hold", {28'd0, out1}, {28'd0, 36'h5A5A00002});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
